// File: rtl/mux_scan_nby1_pkg.sv
// rtl/mux_scan_nby1_pkg.sv - shared encodings and helpers for the scanning N:1 sampler
//
// Purpose: mode encodings, FSM state encodings and a clog2 helper used to
//          size the select/counter width.
// Ports:   none (package).

package mux_scan_nby1_pkg;

   // Mode input encodings
   localparam logic MODE_MAN  = 1'b0;
   localparam logic MODE_SCAN = 1'b1;

   // Sampler FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAN  = 2'd1,
      SCAN = 2'd2
   } state_t;

   // Smallest r with 2**r >= value (returns 0 for value <= 1)
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int k = 0; k < 31; k++) begin
         if ((1 << k) < value) begin
            r = k + 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/mux_nby1_comb.sv
// rtl/mux_nby1_comb.sv - combinational N:1 channel selector with in-range flag
//
// Purpose: picks channel sel out of a packed N*W bus. Out-of-range selects
//          return zero data and in_range=0; no part-select is ever formed
//          from an out-of-range index.
// Ports:
//   i        in   N*W   packed channel data, channel k at [k*W +: W]
//   sel      in   SELW  channel index
//   y        out  W     selected channel data (0 when sel >= N)
//   in_range out  1     sel < N

module mux_nby1_comb
   import mux_scan_nby1_pkg::*;
#(
   parameter int N    = 8,
   parameter int W    = 1,
   parameter int SELW = 3
) (
   input  logic [N*W-1:0]  i,
   input  logic [SELW-1:0] sel,
   output logic [W-1:0]    y,
   output logic            in_range
);

   always_comb begin
      y        = '0;
      in_range = (int'(sel) < N);
      // Equality decode per channel: only constant part-selects are built.
      for (int k = 0; k < N; k++) begin
         if (sel == SELW'(k)) begin
            y = i[k*W +: W];
         end
      end
   end

endmodule

// File: rtl/mux_scan_nby1.sv
// rtl/mux_scan_nby1.sv - registered N:1 channel sampler with manual/scan select and valid/ready output
//
// Purpose: samples one of N W-bit channels into an output register, either
//          from the manual select s or from an internal wrapping scan
//          counter, and presents it to a consumer with a valid/ready
//          handshake. One sample per cycle at full throughput.
// Ports:
//   clk    in   1     rising-edge clock
//   rst    in   1     synchronous active-high reset
//   i      in   N*W   packed channel data
//   s      in   SELW  manual channel select
//   mode   in   1     0 = manual, 1 = scan
//   en     in   1     sampling enable
//   Y      out  W     registered sample
//   ch     out  SELW  channel index Y was taken from
//   valid  out  1     Y/ch hold an unconsumed sample
//   ready  in   1     consumer takes the sample when valid && ready
//   err    out  1     one-cycle pulse after a manual load with s >= N

module mux_scan_nby1
   import mux_scan_nby1_pkg::*;
#(
   parameter int N    = 8,
   parameter int W    = 1,
   parameter int SELW = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N*W-1:0]  i,
   input  logic [SELW-1:0] s,
   input  logic            mode,
   input  logic            en,
   output logic [W-1:0]    Y,
   output logic [SELW-1:0] ch,
   output logic            valid,
   input  logic            ready,
   output logic            err
);

   if (SELW < clog2(N)) begin : g_bad_selw
      $error("mux_scan_nby1: SELW too narrow for N");
   end

   state_t          state;
   logic [SELW-1:0] cnt;
   logic [SELW-1:0] sel;
   logic [W-1:0]    sel_y;
   logic            sel_ok;
   logic            load;

   // The selector is shared: scan mode looks at the counter, manual at s.
   assign sel  = (mode == MODE_SCAN) ? cnt : s;
   // A new sample may enter on the same edge the held one is consumed.
   assign load = en && (!valid || ready);

   mux_nby1_comb #(
      .N    (N),
      .W    (W),
      .SELW (SELW)
   ) u_sel (
      .i        (i),
      .sel      (sel),
      .y        (sel_y),
      .in_range (sel_ok)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         Y     <= '0;
         ch    <= '0;
         valid <= 1'b0;
         err   <= 1'b0;
      end else begin
         err <= 1'b0;

         if (!en) begin
            state <= IDLE;
         end else if (mode == MODE_SCAN) begin
            state <= SCAN;
         end else begin
            state <= MAN;
         end

         if (load) begin
            Y     <= sel_ok ? sel_y : '0;
            ch    <= sel;
            valid <= 1'b1;
            if (mode == MODE_SCAN) begin
               // Explicit wrap keeps cnt below N for non-power-of-two N.
               cnt <= (cnt == SELW'(N - 1)) ? '0 : cnt + 1'b1;
            end else begin
               // Out-of-range manual samples are still delivered as zero.
               err <= !sel_ok;
            end
         end else if (ready) begin
            valid <= 1'b0;
         end
      end
   end

   // The counter never leaves 0..N-1, so a scan load cannot flag err.
   a_no_err_in_scan: assert property (@(posedge clk) disable iff (rst)
      (state == SCAN) |-> !err);

endmodule

// File: tb/tb_mux_scan_nby1.sv
// tb/tb_mux_scan_nby1.sv - scoreboard bench for mux_scan_nby1 (N=8 and N=5 instances)

module tb_mux_scan_nby1;

   logic        clk;
   logic        rst;
   logic [31:0] i_bus;
   logic [2:0]  s;
   logic        mode;
   logic        en;
   logic        ready;

   logic [3:0]  y8, y5;
   logic [2:0]  ch8, ch5;
   logic        v8, v5, e8, e5;

   int compared;
   int mismatched;

   // Reference state per instance: 0 -> N=8, 1 -> N=5
   int          n_of [2];
   int          m_cnt [2];
   bit          m_valid [2];
   bit          m_err [2];
   logic [6:0]  exp_q0 [$];
   logic [6:0]  exp_q1 [$];

   mux_scan_nby1 #(.N(8), .W(4), .SELW(3)) dut8 (
      .clk(clk), .rst(rst), .i(i_bus), .s(s), .mode(mode), .en(en),
      .Y(y8), .ch(ch8), .valid(v8), .ready(ready), .err(e8)
   );

   mux_scan_nby1 #(.N(5), .W(4), .SELW(3)) dut5 (
      .clk(clk), .rst(rst), .i(i_bus[19:0]), .s(s), .mode(mode), .en(en),
      .Y(y5), .ch(ch5), .valid(v5), .ready(ready), .err(e5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s dut%0d actual=%0h required=%0h at %0t", name, d, act, exp, $time);
      end
   endtask

   // Behavioural reference: applied at every rising edge with the inputs just sampled.
   task automatic model_edge();
      for (int d = 0; d < 2; d++) begin
         int c;
         logic [3:0] yv;
         bit ld;
         if (rst) begin
            m_cnt[d] = 0; m_valid[d] = 0; m_err[d] = 0;
            if (d == 0) exp_q0.delete(); else exp_q1.delete();
         end else begin
            ld = en && (!m_valid[d] || ready);
            if (ld) begin
               if (mode) begin
                  c = m_cnt[d];
                  m_cnt[d] = (m_cnt[d] + 1) % n_of[d];
                  m_err[d] = 0;
               end else begin
                  c = int'(s);
                  m_err[d] = (c >= n_of[d]);
               end
               yv = (c < n_of[d]) ? 4'((i_bus >> (c * 4)) & 32'hF) : 4'h0;
               if (d == 0) exp_q0.push_back({3'(c), yv}); else exp_q1.push_back({3'(c), yv});
               m_valid[d] = 1;
            end else begin
               m_err[d] = 0;
               if (ready) m_valid[d] = 0;
            end
         end
      end
   endtask

   task automatic check_dut(input int d, input logic [3:0] y, input logic [2:0] c,
                            input logic v, input logic e);
      int qs;
      logic [6:0] f;
      cmp("valid", d, 32'(v), 32'(m_valid[d]));
      cmp("err", d, 32'(e), 32'(m_err[d]));
      if (v === 1'b1) begin
         qs = (d == 0) ? exp_q0.size() : exp_q1.size();
         cmp("pending_depth", d, 32'(qs), 32'd1);
         if (qs > 0) begin
            f = (d == 0) ? exp_q0[0] : exp_q1[0];
            cmp("ch", d, 32'(c), 32'(f[6:4]));
            cmp("Y", d, 32'(y), 32'(f[3:0]));
            if (ready) begin
               if (d == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
            end
         end
      end
   endtask

   // Monitor: sampled away from the active edge; ready here is what the next edge sees.
   always @(negedge clk) begin
      check_dut(0, y8, ch8, v8, e8);
      check_dut(1, y5, ch5, v5, e5);
   end

   task automatic cyc(input bit r, input bit e, input bit md, input bit rd,
                      input logic [2:0] sv, input logic [31:0] iv);
      rst = r; en = e; mode = md; ready = rd; s = sv; i_bus = iv;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   initial begin
      compared = 0; mismatched = 0;
      n_of[0] = 8; n_of[1] = 5;
      for (int d = 0; d < 2; d++) begin
         m_cnt[d] = 0; m_valid[d] = 0; m_err[d] = 0;
      end
      rst = 1; en = 1; mode = 0; ready = 1; s = 0; i_bus = '1;

      // Reset held with en=1 and all-ones data
      cyc(1, 1, 0, 1, 3'd0, 32'hFFFF_FFFF);
      cyc(1, 1, 0, 1, 3'd0, 32'hFFFF_FFFF);
      @(negedge clk);
      cmp("reset_Y", 0, 32'(y8), 32'd0);
      cmp("reset_ch", 0, 32'(ch8), 32'd0);
      cmp("reset_Y", 1, 32'(y5), 32'd0);
      cmp("reset_ch", 1, 32'(ch5), 32'd0);
      #1;

      // Manual s=5 straight out of reset
      cyc(0, 1, 0, 1, 3'd5, 32'h7654_3210);

      // Scan for 10 cycles with channel k carrying value k
      for (int k = 0; k < 10; k++) cyc(0, 1, 1, 1, 3'd0, 32'h7654_3210);

      // Stall for 3 cycles while data changes, then release
      for (int k = 0; k < 3; k++) cyc(0, 1, 1, 0, 3'($urandom_range(0, 7)), $urandom);
      for (int k = 0; k < 3; k++) cyc(0, 1, 1, 1, 3'd0, 32'h7654_3210);

      // Manual out-of-range for N=5, then an in-range select
      cyc(0, 1, 0, 1, 3'd6, 32'hABCD_1234);
      cyc(0, 1, 0, 1, 3'd2, 32'hABCD_1234);
      cyc(0, 0, 0, 1, 3'd2, 32'hABCD_1234);
      cyc(0, 0, 0, 1, 3'd2, 32'hABCD_1234);

      // Reset in the middle of a stall, then scan restarts at channel 0
      cyc(0, 1, 1, 1, 3'd0, 32'h7654_3210);
      cyc(0, 1, 1, 0, 3'd0, 32'h7654_3210);
      cyc(0, 1, 1, 0, 3'd0, 32'h7654_3210);
      cyc(1, 1, 1, 0, 3'd0, 32'h7654_3210);
      for (int k = 0; k < 4; k++) cyc(0, 1, 1, 1, 3'd0, 32'h7654_3210);

      // Randomised traffic: mode switches, stalls, en gaps, occasional reset
      for (int k = 0; k < 400; k++) begin
         cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
             ($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)), $urandom);
      end

      // Drain
      for (int k = 0; k < 3; k++) cyc(0, 0, 0, 1, 3'd0, 32'h0);
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
